hdlc_tx_framer: RTL and testbench

HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

---
 rtl/hdlc_tx_framer.sv | 185 ++++++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, LSB-first bit stuffing, abort and underrun.
// Define HDLC_TX_IDLE_FLAGS_EN to fill the idle line with back-to-back flags.
module hdlc_tx_framer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_END, S_ABORT
  } state_t;

  state_t     r_state, w_state_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic [2:0] r_ones, w_ones_nx, w_ones_inc;
  logic [7:0] r_shift, w_shift_nx;
  logic [7:0] r_hold, w_hold_nx;
  logic       r_hold_full, w_hold_full_nx;
  logic       r_hold_last, w_hold_last_nx;
  logic       r_shift_last, w_shift_last_nx;
  logic       r_last_in, w_last_in_nx;
  logic       r_end_pend, w_end_pend_nx;
  logic       r_tx, w_bit, w_acc, w_stuff;
  logic       w_go_abort, w_load_ok, w_load_last, w_flag_bit;
  logic [7:0] w_load_data;

  assign Tx_Ready = !Rst && !r_hold_full && !r_last_in &&
                    ((r_state == S_IDLE) || (r_state == S_START) ||
                     (r_state == S_DATA));
  assign w_acc       = Tx_Valid && Tx_Ready;
  assign w_stuff     = (r_state == S_DATA) && (r_ones == 3'd5);
  assign w_load_ok   = r_hold_full || w_acc;
  assign w_load_data = r_hold_full ? r_hold : Tx_Data;
  assign w_load_last = r_hold_full ? r_hold_last : Tx_Last;
  assign w_flag_bit  = (r_cnt != 3'd0) && (r_cnt != 3'd7);
  assign w_ones_inc  = r_shift[0] ? (r_ones + 3'd1) : 3'd0;

  assign Tx              = r_tx;
  assign Tx_ValidFrame   = (r_state == S_START) || (r_state == S_DATA);
  assign Tx_Done         = (r_state == S_END) && (r_cnt == 3'd7);
  assign Tx_AbortedTrans = (r_state == S_ABORT) && (r_cnt == 3'd7);

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_ones_nx       = r_ones;
    w_shift_nx      = r_shift;
    w_hold_nx       = r_hold;
    w_hold_full_nx  = r_hold_full;
    w_hold_last_nx  = r_hold_last;
    w_shift_last_nx = r_shift_last;
    w_last_in_nx    = r_last_in;
    w_end_pend_nx   = r_end_pend;
    w_bit           = 1'b1;
    w_go_abort      = 1'b0;
    if (w_acc) begin
      w_hold_nx      = Tx_Data;
      w_hold_full_nx = 1'b1;
      w_hold_last_nx = Tx_Last;
      if (Tx_Last) w_last_in_nx = 1'b1;
    end
    unique case (r_state)
      S_IDLE: begin
`ifdef HDLC_TX_IDLE_FLAGS_EN
        w_bit    = w_flag_bit;
        w_cnt_nx = r_cnt + 3'd1;
        if ((r_cnt == 3'd7) && w_load_ok) begin
          w_state_nx = S_START;
          w_ones_nx  = 3'd0;
        end
`else
        w_bit = 1'b1;
        if (w_acc) begin
          w_state_nx = S_START;
          w_cnt_nx   = 3'd0;
          w_ones_nx  = 3'd0;
        end
`endif
      end
      S_START: begin
        w_bit    = w_flag_bit;
        w_cnt_nx = r_cnt + 3'd1;
        if (Tx_AbortFrame) begin
          w_go_abort = 1'b1;
        end else if (r_cnt == 3'd7) begin
          w_state_nx      = S_DATA;
          w_shift_nx      = r_hold;
          w_shift_last_nx = r_hold_last;
          w_hold_full_nx  = 1'b0;
        end
      end
      S_DATA: begin
        if (w_stuff) begin
          w_bit     = 1'b0;
          w_ones_nx = 3'd0;
        end else begin
          w_bit      = r_shift[0];
          w_ones_nx  = w_ones_inc;
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_cnt_nx   = r_cnt + 3'd1;
        end
        if (Tx_AbortFrame) begin
          w_go_abort = 1'b1;
        end else if (w_stuff) begin
          if (r_end_pend) begin
            w_state_nx    = S_END;
            w_end_pend_nx = 1'b0;
          end
        end else if (r_cnt == 3'd7) begin
          if (r_shift_last) begin
            // a final run of five ones still owes its stuffed zero
            if (w_ones_inc == 3'd5) w_end_pend_nx = 1'b1;
            else                    w_state_nx    = S_END;
          end else if (w_load_ok) begin
            w_shift_nx      = w_load_data;
            w_shift_last_nx = w_load_last;
            w_hold_full_nx  = 1'b0;
          end else begin
            w_go_abort = 1'b1;
          end
        end
      end
      S_END: begin
        w_bit    = w_flag_bit;
        w_cnt_nx = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          w_state_nx   = S_IDLE;
          w_last_in_nx = 1'b0;
        end
      end
      S_ABORT: begin
        w_bit    = (r_cnt != 3'd0);
        w_cnt_nx = r_cnt + 3'd1;
        if (r_cnt == 3'd7) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_go_abort) begin
      w_state_nx      = S_ABORT;
      w_cnt_nx        = 3'd0;
      w_ones_nx       = 3'd0;
      w_hold_full_nx  = 1'b0;
      w_shift_last_nx = 1'b0;
      w_last_in_nx    = 1'b0;
      w_end_pend_nx   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_ones       <= 3'd0;
      r_shift      <= 8'd0;
      r_hold       <= 8'd0;
      r_hold_full  <= 1'b0;
      r_hold_last  <= 1'b0;
      r_shift_last <= 1'b0;
      r_last_in    <= 1'b0;
      r_end_pend   <= 1'b0;
      r_tx         <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_ones       <= w_ones_nx;
      r_shift      <= w_shift_nx;
      r_hold       <= w_hold_nx;
      r_hold_full  <= w_hold_full_nx;
      r_hold_last  <= w_hold_last_nx;
      r_shift_last <= w_shift_last_nx;
      r_last_in    <= w_last_in_nx;
      r_end_pend   <= w_end_pend_nx;
      r_tx         <= w_bit;
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: byte feeder, per-cycle recorder, bit scoreboard.
// Idle-line checks follow HDLC_TX_IDLE_FLAGS_EN when it is defined.
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Tx_Data = 8'd0;
  logic       Tx_Valid = 1'b0;
  logic       Tx_Last = 1'b0;
  logic       Tx_AbortFrame = 1'b0;
  logic       Tx_Ready, Tx, Tx_ValidFrame;
  logic       Tx_AbortedTrans, Tx_Done;

  int n_chk = 0;
  int n_fail = 0;
  int acc_first = -1;
  logic [8:0] src[$];
  logic exp_q[$];
  logic obs_tx[$], obs_vf[$], obs_dn[$], obs_ab[$], obs_rdy[$];

  always #5 Clk = ~Clk;

  hdlc_tx_framer dut (
    .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
    .Tx_Last(Tx_Last), .Tx_Ready(Tx_Ready),
    .Tx_AbortFrame(Tx_AbortFrame), .Tx(Tx),
    .Tx_ValidFrame(Tx_ValidFrame),
    .Tx_AbortedTrans(Tx_AbortedTrans), .Tx_Done(Tx_Done)
  );

  task automatic cycle();
    @(negedge Clk);
    obs_tx.push_back(Tx);
    obs_vf.push_back(Tx_ValidFrame);
    obs_dn.push_back(Tx_Done);
    obs_ab.push_back(Tx_AbortedTrans);
    obs_rdy.push_back(Tx_Ready);
    if (Tx_Valid && Tx_Ready) begin
      if (acc_first < 0) acc_first = obs_tx.size() - 1;
      if (src.size() > 0) void'(src.pop_front());
    end
    @(posedge Clk);
    #1;
    Tx_Valid = (src.size() > 0);
    if (src.size() > 0) begin
      Tx_Data = src[0][7:0];
      Tx_Last = src[0][8];
    end else begin
      Tx_Data = 8'd0;
      Tx_Last = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_tx.delete(); obs_vf.delete(); obs_dn.delete();
    obs_ab.delete(); obs_rdy.delete(); exp_q.delete();
    acc_first = -1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    src.push_back({last, b});
  endtask

  task automatic exp_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
  endtask

  task automatic exp_abort();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(1'b1);
  endtask

  task automatic exp_byte(input logic [7:0] b, inout int ones);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      if (b[i]) ones++;
      else ones = 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
  endtask

  function automatic int find_rise(input int from);
    for (int i = from; i < obs_vf.size(); i++)
      if (obs_vf[i] === 1'b1 && (i == 0 || obs_vf[i-1] !== 1'b1))
        return i;
    return -1;
  endfunction

  function automatic int cnt1(input logic q[$], input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < q.size(); i++)
      if (q[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    clear_obs();
    Rst = 1'b1;
    cycle();
    n_chk++;
    if (obs_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready_in_reset: got %b want 0", obs_rdy[0]);
    end
    Rst = 1'b0;
    cycle();
    n_chk++;
    if (obs_tx[1] !== 1'b1) begin
      n_fail++; $display("FAIL rst_tx: got %b want 1", obs_tx[1]);
    end
    n_chk++;
    if (obs_rdy[1] !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready: got %b want 1", obs_rdy[1]);
    end
    n_chk++;
    if ({obs_vf[1], obs_dn[1], obs_ab[1]} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags: got %b%b%b want 000", obs_vf[1], obs_dn[1], obs_ab[1]);
    end
  endtask

  task automatic test_single_zero();
    int v, len, ones;
    logic e;
    logic [7:0] f;
    clear_obs();
    repeat (10) cycle();
    send(8'h00, 1'b1);
    ones = 0;
    exp_flag(); exp_byte(8'h00, ones); exp_flag();
    len = exp_q.size();
    v = -1;
    for (int k = 0; k < 40 && v < 0; k++) begin cycle(); v = find_rise(0); end
    n_chk++;
    if (v < 0) begin n_fail++; $display("FAIL zero_start: got timeout want rise"); return; end
    while (obs_tx.size() < v + len + 4) cycle();
    for (int i = 0; i < len; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_tx[v+1+i] !== e) begin
        n_fail++; $display("FAIL zero_bit%0d: got %b want %b", i, obs_tx[v+1+i], e);
      end
    end
    n_chk++;
    if (cnt1(obs_vf, 0, obs_vf.size() - 1) != 16) begin
      n_fail++; $display("FAIL zero_vf_len: got %0d want 16", cnt1(obs_vf, 0, obs_vf.size() - 1));
    end
    n_chk++;
    if (cnt1(obs_dn, 0, obs_dn.size() - 1) != 1 || obs_dn[v+23] !== 1'b1) begin
      n_fail++; $display("FAIL zero_done: got %0d pulses want 1 at v+23", cnt1(obs_dn, 0, obs_dn.size() - 1));
    end
`ifdef HDLC_TX_IDLE_FLAGS_EN
    n_chk++;
    if (v - acc_first < 1 || v - acc_first > 8) begin
      n_fail++; $display("FAIL flag_latency: got %0d want 1..8", v - acc_first);
    end
    f = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (obs_tx[v-7+i] !== f[i]) begin
        n_fail++; $display("FAIL idle_flag_bit%0d: got %b want %b", i, obs_tx[v-7+i], f[i]);
      end
    end
`else
    n_chk++;
    if (v != acc_first + 1) begin
      n_fail++; $display("FAIL start_latency: got %0d want %0d", v, acc_first + 1);
    end
    n_chk++;
    if (cnt1(obs_tx, 0, v) != v + 1) begin
      n_fail++; $display("FAIL idle_ones: got %0d want %0d", cnt1(obs_tx, 0, v), v + 1);
    end
`endif
  endtask

  task automatic test_stuffing();
    int v, len, ones, run, mx;
    logic e;
    clear_obs();
    send(8'hFF, 1'b0); send(8'hFF, 1'b1);
    ones = 0;
    exp_flag(); exp_byte(8'hFF, ones); exp_byte(8'hFF, ones); exp_flag();
    len = exp_q.size();
    v = -1;
    for (int k = 0; k < 40 && v < 0; k++) begin cycle(); v = find_rise(0); end
    n_chk++;
    if (v < 0) begin n_fail++; $display("FAIL stuff_start: got timeout want rise"); return; end
    while (obs_tx.size() < v + len + 4) cycle();
    for (int i = 0; i < len; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_tx[v+1+i] !== e) begin
        n_fail++; $display("FAIL stuff_bit%0d: got %b want %b", i, obs_tx[v+1+i], e);
      end
    end
    run = 0; mx = 0;
    for (int i = v + 9; i <= v + len - 8; i++) begin
      run = (obs_tx[i] === 1'b1) ? run + 1 : 0;
      if (run > mx) mx = run;
    end
    n_chk++;
    if (mx > 5) begin n_fail++; $display("FAIL stuff_run: got %0d want <=5", mx); end
    n_chk++;
    if (cnt1(obs_dn, 0, obs_dn.size() - 1) != 1) begin
      n_fail++; $display("FAIL stuff_done: got %0d want 1", cnt1(obs_dn, 0, obs_dn.size() - 1));
    end
  endtask

  task automatic test_back_to_back();
    int v1, v2, len1, len2, ones;
    logic [7:0] r1, r2, r3;
    logic e;
    clear_obs();
    r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    send(8'h7E, 1'b0); send(r1, 1'b0); send(8'hF8, 1'b1);
    send(r2, 1'b0); send(8'hF0, 1'b0); send(8'h3F, 1'b0); send(r3, 1'b1);
    ones = 0;
    exp_flag(); exp_byte(8'h7E, ones); exp_byte(r1, ones);
    exp_byte(8'hF8, ones); exp_flag();
    len1 = exp_q.size();
    ones = 0;
    exp_flag(); exp_byte(r2, ones); exp_byte(8'hF0, ones);
    exp_byte(8'h3F, ones); exp_byte(r3, ones); exp_flag();
    len2 = exp_q.size() - len1;
    v1 = -1; v2 = -1;
    for (int k = 0; k < 300 && v2 < 0; k++) begin
      cycle();
      v1 = find_rise(0);
      if (v1 >= 0) v2 = find_rise(v1 + 1);
    end
    n_chk++;
    if (v2 < 0) begin n_fail++; $display("FAIL b2b_start: got timeout want two rises"); return; end
    while (obs_tx.size() < v2 + len2 + 4) cycle();
    for (int i = 0; i < len1; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_tx[v1+1+i] !== e) begin
        n_fail++; $display("FAIL b2b_f1_bit%0d: got %b want %b", i, obs_tx[v1+1+i], e);
      end
    end
    for (int i = 0; i < len2; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_tx[v2+1+i] !== e) begin
        n_fail++; $display("FAIL b2b_f2_bit%0d: got %b want %b", i, obs_tx[v2+1+i], e);
      end
    end
    n_chk++;
    if (cnt1(obs_rdy, v1 + len1 - 8, v1 + len1 - 1) != 0) begin
      n_fail++; $display("FAIL b2b_ready_endflag: got %0d high want 0", cnt1(obs_rdy, v1 + len1 - 8, v1 + len1 - 1));
    end
    n_chk++;
    if (cnt1(obs_dn, 0, obs_dn.size() - 1) != 2) begin
      n_fail++; $display("FAIL b2b_done: got %0d want 2", cnt1(obs_dn, 0, obs_dn.size() - 1));
    end
  endtask

  task automatic test_abort();
    int v, len, ones;
    logic e;
    clear_obs();
    send(8'h00, 1'b0); send(8'hA5, 1'b0);
    send(8'h3C, 1'b0); send(8'h81, 1'b1);
    ones = 0;
    exp_flag(); exp_byte(8'h00, ones);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_abort();
    len = exp_q.size();
    v = -1;
    for (int k = 0; k < 40 && v < 0; k++) begin cycle(); v = find_rise(0); end
    n_chk++;
    if (v < 0) begin n_fail++; $display("FAIL abort_start: got timeout want rise"); return; end
    while (obs_tx.size() < v + 19) cycle();
    Tx_AbortFrame = 1'b1;
    src.delete();
    Tx_Valid = 1'b0;
    cycle();
    Tx_AbortFrame = 1'b0;
    while (obs_tx.size() < v + 35) cycle();
    for (int i = 0; i < len; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_tx[v+1+i] !== e) begin
        n_fail++; $display("FAIL abort_bit%0d: got %b want %b", i, obs_tx[v+1+i], e);
      end
    end
    n_chk++;
    if (cnt1(obs_ab, 0, obs_ab.size() - 1) != 1 || obs_ab[v+27] !== 1'b1) begin
      n_fail++; $display("FAIL abort_pulse: got %0d pulses want 1 at v+27", cnt1(obs_ab, 0, obs_ab.size() - 1));
    end
    n_chk++;
    if (cnt1(obs_dn, 0, obs_dn.size() - 1) != 0) begin
      n_fail++; $display("FAIL abort_done: got %0d want 0", cnt1(obs_dn, 0, obs_dn.size() - 1));
    end
    n_chk++;
    if (cnt1(obs_rdy, v + 20, v + 27) + cnt1(obs_vf, v + 20, v + 34) != 0) begin
      n_fail++; $display("FAIL abort_ready_vf: got %0d high want 0", cnt1(obs_rdy, v + 20, v + 27) + cnt1(obs_vf, v + 20, v + 34));
    end
`ifndef HDLC_TX_IDLE_FLAGS_EN
    n_chk++;
    if (cnt1(obs_tx, v + 29, v + 34) != 6) begin
      n_fail++; $display("FAIL abort_idle: got %0d ones want 6", cnt1(obs_tx, v + 29, v + 34));
    end
`endif
  endtask

  task automatic test_underrun(input bit with_abort);
    int v, len, ones;
    logic e;
    clear_obs();
    send(8'h5A, 1'b0);
    ones = 0;
    exp_flag(); exp_byte(8'h5A, ones); exp_abort();
    len = exp_q.size();
    v = -1;
    for (int k = 0; k < 40 && v < 0; k++) begin cycle(); v = find_rise(0); end
    n_chk++;
    if (v < 0) begin n_fail++; $display("FAIL underrun_start: got timeout want rise"); return; end
    while (obs_tx.size() < v + 15) cycle();
    Tx_AbortFrame = with_abort;
    cycle();
    Tx_AbortFrame = 1'b0;
    while (obs_tx.size() < v + 40) cycle();
    for (int i = 0; i < len; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_tx[v+1+i] !== e) begin
        n_fail++; $display("FAIL underrun%0d_bit%0d: got %b want %b", with_abort, i, obs_tx[v+1+i], e);
      end
    end
    n_chk++;
    if (cnt1(obs_ab, 0, obs_ab.size() - 1) != 1 || obs_ab[v+23] !== 1'b1) begin
      n_fail++; $display("FAIL underrun%0d_pulse: got %0d pulses want 1 at v+23", with_abort, cnt1(obs_ab, 0, obs_ab.size() - 1));
    end
    n_chk++;
    if (cnt1(obs_dn, 0, obs_dn.size() - 1) != 0) begin
      n_fail++; $display("FAIL underrun%0d_done: got %0d want 0", with_abort, cnt1(obs_dn, 0, obs_dn.size() - 1));
    end
  endtask

  task automatic test_reset_mid();
    int v, len, ones;
    logic e;
    clear_obs();
    send(8'h0F, 1'b0); send(8'h55, 1'b1);
    v = -1;
    for (int k = 0; k < 40 && v < 0; k++) begin cycle(); v = find_rise(0); end
    n_chk++;
    if (v < 0) begin n_fail++; $display("FAIL rmid_start: got timeout want rise"); return; end
    while (obs_tx.size() < v + 12) cycle();
    Rst = 1'b1;
    src.delete();
    Tx_Valid = 1'b0;
    cycle();
    Rst = 1'b0;
    repeat (30) cycle();
    n_chk++;
    if (obs_tx[v+13] !== 1'b1 || obs_rdy[v+13] !== 1'b1) begin
      n_fail++; $display("FAIL rmid_tx_ready: got %b%b want 11", obs_tx[v+13], obs_rdy[v+13]);
    end
    n_chk++;
    if (cnt1(obs_vf, v + 13, v + 42) + cnt1(obs_dn, v + 12, v + 42) + cnt1(obs_ab, v + 12, v + 42) != 0) begin
      n_fail++; $display("FAIL rmid_quiet: got %0d pulses/vf want 0", cnt1(obs_vf, v + 13, v + 42) + cnt1(obs_dn, v + 12, v + 42) + cnt1(obs_ab, v + 12, v + 42));
    end
`ifndef HDLC_TX_IDLE_FLAGS_EN
    n_chk++;
    if (cnt1(obs_tx, v + 13, v + 42) != 30) begin
      n_fail++; $display("FAIL rmid_idle: got %0d ones want 30", cnt1(obs_tx, v + 13, v + 42));
    end
`endif
    clear_obs();
    send(8'hC3, 1'b1);
    ones = 0;
    exp_flag(); exp_byte(8'hC3, ones); exp_flag();
    len = exp_q.size();
    v = -1;
    for (int k = 0; k < 40 && v < 0; k++) begin cycle(); v = find_rise(0); end
    n_chk++;
    if (v < 0) begin n_fail++; $display("FAIL rmid_next_start: got timeout want rise"); return; end
    while (obs_tx.size() < v + len + 4) cycle();
    for (int i = 0; i < len; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_tx[v+1+i] !== e) begin
        n_fail++; $display("FAIL rmid_next_bit%0d: got %b want %b", i, obs_tx[v+1+i], e);
      end
    end
    n_chk++;
    if (cnt1(obs_dn, 0, obs_dn.size() - 1) != 1) begin
      n_fail++; $display("FAIL rmid_next_done: got %0d want 1", cnt1(obs_dn, 0, obs_dn.size() - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_zero();
    test_stuffing();
    test_back_to_back();
    test_abort();
    test_underrun(1'b0);
    test_underrun(1'b1);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
